apu_sequencer: RTL and testbench
================================

# apu_sequencer

Autonomous pattern sequencer and register-write arbiter for the pulse channel. It steps through a 16-entry note pattern at a tempo derived from the frame counter's quarter-frame clock, and writes the pulse channel's four 8-bit registers (duty/volume, sweep, timer-low, length/timer-high). A host write port shares the same register bank with strict priority over the sequencer. It sits between the serial decoder and the pulse channel, and replaces the decoder as the register source.

## Interface
- `STEPS`, default 16: pattern length; power of two.
- `TEMPO_W`, default 4: width of the tempo field.

Ports:
- `clk`  in  1  system clock (4800 Hz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `qtr_clk`  in  1  quarter-frame clock from the frame counter (240 Hz); a rising edge is one tick.
- `play`  in  1  level; 1 runs the pattern, 0 stops and mutes.
- `tempo`  in  TEMPO_W  quarter-frame ticks per step minus 1.
- `host_we`  in  1  host register write strobe.
- `host_addr`  in  2  host register select, 0..3.
- `host_data`  in  8  host write data.
- `reg_0`, `reg_1`, `reg_2`, `reg_3`  out  8 each  pulse-channel registers.
- `reg3_wr`  out  1  one-cycle pulse on any write to `reg_3`; reloads the length counter.
- `step`  out  log2(STEPS)  current pattern index.
- `busy`  out  1  sequencer write burst in progress.

## Operation
- Pattern entry format is 18 bits: {rest, duty[1:0], vol[3:0], timer[10:0]}.
- Write burst for a note:
  - W0: `reg_0` = {duty, 1, 1, vol}.
  - W1: `reg_1` = 8'h00 (sweep off).
  - W2: `reg_2` = timer[7:0].
  - W3: `reg_3` = {5'b00001, timer[10:8]}, and `reg3_wr` = 1.
- For a rest entry, W0 writes `reg_0` = 8'h30 (volume 0), then the FSM goes directly to WAIT.
- FSM states: IDLE, W0, W1, W2, W3, WAIT, MUTE.
- IDLE → W0 when `play` = 1; `step` is 0 on this entry.
- Wn → Wn+1 each cycle; W3 → WAIT.
- On entry to WAIT, the tick counter loads `tempo`.
- In WAIT, on each tick: if the counter is 0, increment `step` (STEPS-1 wraps to 0) and go to W0; otherwise decrement the counter.
- Any state except IDLE/MUTE with `play` = 0 → MUTE. MUTE writes `reg_0` = 8'h30, resets `step` to 0, and goes to IDLE.
- Host arbitration:
  - A host write in any state updates `reg[host_addr]` that cycle.
  - If the sequencer is in W0–W3 or MUTE during a host write, it stalls and holds its state; it retries the following cycle.
  - A host write to address 3 pulses `reg3_wr`.
- Ticks arriving in W0–W3, MUTE or IDLE are discarded; only WAIT counts ticks.
- Tick detection: a registered `qtr_clk` sample `q`, with tick = `qtr_clk` & ~`q`.

## Timing
- Reset values:
  - `reg_0` = 8'h30, `reg_1` = 8'h00, `reg_2` = 8'h00, `reg_3` = 8'h00.
  - `step` = 0, `busy` = 0, `reg3_wr` = 0.
  - State is IDLE; the tick counter and the `qtr_clk` sample are 0.
- `play` sampled 1 in IDLE at edge n gives state W0 at n+1, with no host contention.
- New register values become visible as follows:
  - `reg_0` at n+2.
  - `reg_1` at n+3.
  - `reg_2` at n+4.
  - `reg_3` at n+5, with `reg3_wr` high for that one cycle.
- `busy` = 1 exactly while the state is W0–W3 or MUTE.
- Step period = (`tempo`+1) ticks counted from WAIT entry. `tempo` changes take effect at the next WAIT entry.
- `play` falling during WAIT or W0–W3 gives MUTE on the next cycle, `reg_0` = 8'h30 one cycle later, then IDLE.
- Each stalled host cycle delays the burst by exactly one cycle.
- `rst_n` low mid-burst restores all reset values immediately; partial writes are not completed.

## Structure
- Shared package `apu_pkg` holds:
  - the state enum;
  - the pattern entry field positions;
  - the constants MUTE_REG0 = 8'h30 and LEN_IDX = 5'b00001.
- Sub-module `pattern_rom`: combinational, indexed by `step`, 16 × 18-bit contents. It is instantiated once.
- The register bank, arbiter, tick detector and FSM live in `apu_sequencer`.

## Test plan
- Reset with `play` = 0 → registers read 30/00/00/00, IDLE, `busy` = 0, and `reg3_wr` never pulses.
- `play` = 1, `tempo` = 0, entry 0 = {0, 2'b10, 4'hF, 11'h0FE} → `reg_0` = 8'hBF at n+2, `reg_2` = 8'hFE at n+4, `reg_3` = 8'h08 at n+5 with a single `reg3_wr`; `step` advances on the first tick in WAIT.
- `tempo` = 3 → exactly 4 ticks between successive W0 entries; after 16 steps `step` wraps to 0 and entry 0 is rewritten.
- `host_we` with `host_addr` = 2 and data 8'h55 during W1 → `reg_2` = 8'h55 and the burst stalls 1 cycle. The subsequent W2 then overwrites `reg_2` with the pattern value, and `reg_3` lands at n+6.
- `play` dropped during W2 → MUTE the next cycle, `reg_0` = 8'h30, `step` = 0, IDLE, and no `reg3_wr`.
- Rest entry → only `reg_0` is written (8'h30); `reg_1`–`reg_3` are unchanged and WAIT begins at n+2.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared state type, pattern entry layout and register constants for the pulse sequencer
package apu_pkg;
  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3, WAIT, MUTE} state_e;
  localparam int ENTRY_W = 18;
  localparam int REST_B = 17;
  localparam int DUTY_LSB = 15;
  localparam int VOL_LSB = 11;
  localparam int TIMER_LSB = 0;
  localparam logic [7:0] MUTE_REG0 = 8'h30;
  localparam logic [4:0] LEN_IDX = 5'b00001;
  localparam logic [ENTRY_W-1:0] REST = 18'h20000;
  function automatic logic [ENTRY_W-1:0] note(input logic [1:0] duty, input logic [3:0] vol,
                                              input logic [10:0] timer);
    return {1'b0, duty, vol, timer};
  endfunction
endpackage

// File: rtl/pattern_rom.sv
// pattern_rom: fixed 16-entry note pattern, combinational lookup by step index
module pattern_rom import apu_pkg::*; (
  input  logic [3:0]         idx,
  output logic [ENTRY_W-1:0] entry
);
  localparam logic [ENTRY_W-1:0] ROM [16] = '{
    note(2'd2, 4'hF, 11'h0FE), note(2'd1, 4'hC, 11'h1FC),
    note(2'd0, 4'h8, 11'h2A9), REST,
    note(2'd3, 4'hA, 11'h17D), note(2'd2, 4'h6, 11'h7FF),
    note(2'd1, 4'hF, 11'h000), REST,
    note(2'd2, 4'h9, 11'h0D5), note(2'd0, 4'h3, 11'h3F8),
    note(2'd3, 4'hF, 11'h11C), note(2'd1, 4'h7, 11'h6A3),
    REST,                      note(2'd2, 4'hB, 11'h2E4),
    note(2'd0, 4'h1, 11'h08E), note(2'd3, 4'h5, 11'h54C)
  };
  assign entry = ROM[idx];
endmodule

// File: rtl/apu_sequencer.sv
// apu_sequencer: steps the note pattern at a quarter-frame tempo and arbitrates pulse register writes with the host
module apu_sequencer import apu_pkg::*; #(
  parameter int STEPS   = 16,
  parameter int TEMPO_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     qtr_clk,
  input  logic                     play,
  input  logic [TEMPO_W-1:0]       tempo,
  input  logic                     host_we,
  input  logic [1:0]               host_addr,
  input  logic [7:0]               host_data,
  output logic [7:0]               reg_0,
  output logic [7:0]               reg_1,
  output logic [7:0]               reg_2,
  output logic [7:0]               reg_3,
  output logic                     reg3_wr,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     busy
);
  localparam int SW = $clog2(STEPS);
  state_e state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [TEMPO_W-1:0] cnt_q, cnt_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic qtr_q, wr_q, wr_d, tick, stall;
  logic [ENTRY_W-1:0] entry;
  pattern_rom u_rom (.idx(4'(step_q)), .entry(entry));
  assign tick = qtr_clk & ~qtr_q;
  assign busy = state_q inside {W0, W1, W2, W3, MUTE};
  assign stall = host_we & busy;
  assign {reg_3, reg_2, reg_1, reg_0} = regs_q;
  assign reg3_wr = wr_q;
  assign step = step_q;
  // state, register bank and tick edge sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      qtr_q   <= 1'b0;
      wr_q    <= 1'b0;
      regs_q  <= {8'h00, 8'h00, 8'h00, MUTE_REG0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_clk;
      wr_q    <= wr_d;
      regs_q  <= regs_d;
    end
  // sequencer next state and burst writes; a host write freezes any writing state and always lands
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    wr_d    = 1'b0;
    if (!stall)
      case (state_q)
        IDLE: if (play) begin
          state_d = W0;
          step_d  = '0;
        end
        W0: if (!play) state_d = MUTE;
          else if (entry[REST_B]) begin
            regs_d[0] = MUTE_REG0;
            cnt_d     = tempo;
            state_d   = WAIT;
          end else begin
            regs_d[0] = {entry[DUTY_LSB +: 2], 2'b11, entry[VOL_LSB +: 4]};
            state_d   = W1;
          end
        W1: if (!play) state_d = MUTE;
          else begin
            regs_d[1] = 8'h00;
            state_d   = W2;
          end
        W2: if (!play) state_d = MUTE;
          else begin
            regs_d[2] = entry[TIMER_LSB +: 8];
            state_d   = W3;
          end
        W3: if (!play) state_d = MUTE;
          else begin
            regs_d[3] = {LEN_IDX, entry[TIMER_LSB + 8 +: 3]};
            wr_d      = 1'b1;
            cnt_d     = tempo;
            state_d   = WAIT;
          end
        WAIT: if (!play) state_d = MUTE;
          else if (tick) begin
            if (cnt_q == '0) begin
              step_d  = step_q + 1'b1;
              state_d = W0;
            end else cnt_d = cnt_q - 1'b1;
          end
        MUTE: begin
          regs_d[0] = MUTE_REG0;
          step_d    = '0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    if (host_we) begin
      regs_d[host_addr] = host_data;
      wr_d = wr_d | (host_addr == 2'd3);
    end
  end
endmodule

// File: tb/tb_apu_sequencer.sv
// tb_apu_sequencer: directed and randomized checks of the pulse sequencer against a behavioural model
module tb_apu_sequencer;
  logic clk, rst_n, qtr_clk, play, host_we, reg3_wr, busy;
  logic [3:0] tempo, step;
  logic [1:0] host_addr;
  logic [7:0] host_data, reg_0, reg_1, reg_2, reg_3;
  int checks, failures;
  int m_ph;
  logic [3:0] m_step, m_cnt;
  logic m_q, m_wr;
  logic [7:0] m_reg [4];
  logic [17:0] tbl [16];

  apu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .qtr_clk(qtr_clk), .play(play), .tempo(tempo),
    .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
    .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3),
    .reg3_wr(reg3_wr), .step(step), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [17:0] nt(input logic [1:0] d, input logic [3:0] v, input logic [10:0] t);
    return {1'b0, d, v, t};
  endfunction

  function automatic logic [7:0] burst_val(input logic [17:0] e, input int k);
    if (k == 0) return e[17] ? 8'h30 : {e[16:15], 2'b11, e[14:11]};
    if (k == 1) return 8'h00;
    if (k == 2) return e[7:0];
    return {5'b00001, e[10:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_step = 0; m_cnt = 0; m_q = 0; m_wr = 0;
    m_reg = '{8'h30, 8'h00, 8'h00, 8'h00};
  endtask

  // phases: 0 idle, 1..4 burst slot k=ph-1, 5 waiting for ticks, 6 muting
  task automatic model_step();
    logic tk;
    logic [17:0] e;
    int k;
    bit mb;
    tk = qtr_clk && !m_q;
    m_q = qtr_clk;
    m_wr = 0;
    e = tbl[m_step];
    mb = (m_ph >= 1 && m_ph <= 4) || m_ph == 6;
    if (!(host_we && mb)) begin
      if (m_ph == 0) begin
        if (play) begin m_ph = 1; m_step = 0; end
      end else if (m_ph == 6) begin
        m_reg[0] = 8'h30; m_step = 0; m_ph = 0;
      end else if (!play) m_ph = 6;
      else if (m_ph == 5) begin
        if (tk) begin
          if (m_cnt == 0) begin m_step = 4'((m_step + 1) % 16); m_ph = 1; end
          else m_cnt = m_cnt - 1;
        end
      end else begin
        k = m_ph - 1;
        m_reg[k] = burst_val(e, k);
        m_wr = (k == 3);
        if (k == 3 || (k == 0 && e[17])) begin m_ph = 5; m_cnt = tempo; end
        else m_ph = m_ph + 1;
      end
    end
    if (host_we) begin
      m_reg[host_addr] = host_data;
      if (host_addr == 2'd3) m_wr = 1;
    end
  endtask

  task automatic compare_all();
    chk("reg_0", reg_0, m_reg[0]);
    chk("reg_1", reg_1, m_reg[1]);
    chk("reg_2", reg_2, m_reg[2]);
    chk("reg_3", reg_3, m_reg[3]);
    chk("reg3_wr", reg3_wr, m_wr);
    chk("step", step, m_step);
    chk("busy", busy, (m_ph >= 1 && m_ph <= 4) || m_ph == 6);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 0; play = 0; qtr_clk = 0; host_we = 0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1;
  endtask

  initial begin
    checks = 0; failures = 0;
    tbl = '{nt(2, 4'hF, 11'h0FE), nt(1, 4'hC, 11'h1FC), nt(0, 4'h8, 11'h2A9), 18'h20000,
            nt(3, 4'hA, 11'h17D), nt(2, 4'h6, 11'h7FF), nt(1, 4'hF, 11'h000), 18'h20000,
            nt(2, 4'h9, 11'h0D5), nt(0, 4'h3, 11'h3F8), nt(3, 4'hF, 11'h11C), nt(1, 4'h7, 11'h6A3),
            18'h20000, nt(2, 4'hB, 11'h2E4), nt(0, 4'h1, 11'h08E), nt(3, 4'h5, 11'h54C)};
    rst_n = 0; play = 0; qtr_clk = 0; tempo = 0; host_we = 0; host_addr = 0; host_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_0", reg_0, 8'h30);
    chk("rst_reg_1", reg_1, 8'h00);
    chk("rst_reg_2", reg_2, 8'h00);
    chk("rst_reg_3", reg_3, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_reg3_wr", reg3_wr, 0);
    rst_n = 1;
    repeat (5) cyc();

    play = 1;
    cyc(); chk("n0_busy", busy, 1);
    cyc(); chk("n0_reg_0", reg_0, 8'hBF);
    cyc(); cyc(); chk("n0_reg_2", reg_2, 8'hFE);
    cyc(); chk("n0_reg_3", reg_3, 8'h08); chk("n0_wr", reg3_wr, 1);
    cyc(); chk("n0_wr_once", reg3_wr, 0); chk("n0_wait", busy, 0);
    qtr_clk = 1;
    cyc(); chk("n0_step_adv", step, 1); chk("n0_next_burst", busy, 1);
    qtr_clk = 0;
    repeat (6) cyc();

    do_reset();
    play = 1;
    cyc(); cyc();
    host_we = 1; host_addr = 2; host_data = 8'h55;
    cyc();
    host_we = 0;
    chk("st_host_reg_2", reg_2, 8'h55); chk("st_busy", busy, 1);
    cyc(); chk("st_no_reg_2_yet", reg_2, 8'h55);
    cyc(); chk("st_reg_2", reg_2, 8'hFE);
    cyc(); chk("st_reg_3", reg_3, 8'h08); chk("st_wr", reg3_wr, 1);

    do_reset();
    play = 1;
    cyc(); cyc(); cyc();
    play = 0;
    cyc(); chk("dr_mute", busy, 1);
    cyc(); chk("dr_reg_0", reg_0, 8'h30); chk("dr_step", step, 0);
    chk("dr_idle", busy, 0); chk("dr_wr", reg3_wr, 0);
    cyc();

    play = 1;
    cyc(); cyc();
    rst_n = 0;
    #1;
    chk("ar_reg_0", reg_0, 8'h30); chk("ar_busy", busy, 0); chk("ar_step", step, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1; play = 0;

    do_reset();
    play = 1; tempo = 0;
    cyc();
    for (int s = 0; s < 3; s++) begin
      repeat (4) cyc();
      qtr_clk = 1;
      cyc();
      qtr_clk = 0;
    end
    chk("rs_step", step, 3);
    cyc();
    chk("rs_reg_0", reg_0, 8'h30); chk("rs_wait", busy, 0);
    chk("rs_reg_1", reg_1, 8'h00); chk("rs_reg_2", reg_2, 8'hA9);
    chk("rs_reg_3", reg_3, 8'h0A); chk("rs_wr", reg3_wr, 0);

    do_reset();
    play = 1; tempo = 3;
    for (int i = 0; i < 450; i++) begin
      qtr_clk = (i % 4) >= 2;
      cyc();
    end

    do_reset();
    play = 1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, play ? 99 : 9) == 0) play = ~play;
      if ($urandom_range(0, 2) == 0) qtr_clk = ~qtr_clk;
      tempo = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      host_we = ($urandom_range(0, 9) == 0);
      host_addr = 2'($urandom_range(0, 3));
      host_data = 8'($urandom);
      cyc();
    end
    host_we = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
